// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Fetch-stage sequencer that decides every cycle whether the PC advances,
// holds or jumps, handles the instruction-memory request/ready handshake,
// load-use stalls and EX-stage redirects, and flags when the fetched word is
// to be captured into IF/ID.
//
// Optional feature macro: FETCH_PERF_EN adds three saturating performance
// counters (fetches, PC stalls outside BOOT, redirects) and their ports.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pc_cur            current PC (PC register output)
//   hazard_stall      load-use stall from the ID-stage hazard unit
//   redirect_valid    EX-stage taken branch/jump pulse
//   redirect_target   redirect destination (bits [1:0] ignored)
//   imem_ready        instruction memory returns data this cycle
//   imem_req          fetch request
//   imem_addr         fetch address (always pc_cur)
//   PC_in             next PC to the PC register
//   stall_PC          PC register hold
//   flush_IF_ID       invalidate the IF/ID register
//   if_valid          capture the fetched word into IF/ID
//   perf_*_cnt        performance counters (FETCH_PERF_EN only)
module fetch_pc_ctrl #(
  parameter int PC_INC = 4,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC_in,
  output logic        stall_PC,
  output logic        flush_IF_ID,
  output logic        if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_fetch_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nxt;
  logic [31:0] tgt_in;
  logic [31:0] pc_seq;

  // Targets are word aligned; the low two bits are dropped wherever used.
  assign tgt_in    = redirect_target & 32'hFFFF_FFFC;
  assign pc_seq    = pc_cur + 32'(PC_INC);
  assign imem_addr = pc_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    case (state)
      BOOT: begin
        if (redirect_valid) begin
          pend_target_nxt = tgt_in;
          state_nxt       = DRAIN;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // A redirect that coincides with ready is applied directly; only an
        // unanswered request forces us to park the target and drain.
        if (redirect_valid && !imem_ready) begin
          pend_target_nxt = tgt_in;
          state_nxt       = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) pend_target_nxt = tgt_in;
        if (imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    stall_PC    = 1'b1;
    PC_in       = pc_cur;
    flush_IF_ID = 1'b0;
    if_valid    = 1'b0;
    if (reset) begin
      PC_in = '0;
    end else begin
      flush_IF_ID = redirect_valid;
      case (state)
        BOOT: ;
        FETCH: begin
          imem_req = 1'b1;
          if (redirect_valid) begin
            if (imem_ready) begin
              PC_in    = tgt_in;
              stall_PC = 1'b0;
            end
          end else if (imem_ready && !hazard_stall) begin
            PC_in    = pc_seq;
            stall_PC = 1'b0;
            if_valid = 1'b1;
          end
        end
        DRAIN: begin
          // The outstanding request is completed at the old address; its
          // data is dropped and the newest redirect target is taken.
          imem_req = 1'b1;
          if (imem_ready) begin
            PC_in    = redirect_valid ? tgt_in : pend_target;
            stall_PC = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt    <= '0;
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      perf_fetch_cnt    <= sat_inc(perf_fetch_cnt, if_valid);
      perf_stall_cnt    <= sat_inc(perf_stall_cnt, stall_PC && (state != BOOT));
      perf_redirect_cnt <= sat_inc(perf_redirect_cnt, redirect_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC_in;
  logic        stall_PC;
  logic        flush_IF_ID;
  logic        if_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fetch_pc_ctrl #(.PC_INC(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur          (pc_cur),
    .hazard_stall    (hazard_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_ready      (imem_ready),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .PC_in           (PC_in),
    .stall_PC        (stall_PC),
    .flush_IF_ID     (flush_IF_ID),
    .if_valid        (if_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        hz;
    logic        rv;
    logic [31:0] rt;
    logic        rdy;
    logic        e_req;
    logic        e_stall;
    logic [31:0] e_pcin;
    logic        e_flush;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [31:0] pc, logic hz, logic rv,
                              logic [31:0] rt, logic rdy, logic e_req,
                              logic e_stall, logic [31:0] e_pcin,
                              logic e_flush, logic e_valid);
    vec_t v;
    v.rst = rst; v.pc = pc; v.hz = hz; v.rv = rv; v.rt = rt; v.rdy = rdy;
    v.e_req = e_req; v.e_stall = e_stall; v.e_pcin = e_pcin;
    v.e_flush = e_flush; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic hz,
                       input logic rv, input logic [31:0] rt, input logic rdy);
    reset = rst; pc_cur = pc; hazard_stall = hz;
    redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
  endtask

  initial begin
    // rst pc hz rv rt rdy | req stall PC_in flush valid
    vecs.push_back(mk(1, 32'h0,   0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 0)); // 0 reset
    vecs.push_back(mk(1, 32'h8,   0, 1, 32'h55,  1, 0, 1, 32'h0,   0, 0)); // 1 redirect ignored in reset
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 0)); // 2 BOOT
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 32'h4,   0, 1)); // 3 fetch
    vecs.push_back(mk(0, 32'h4,   0, 0, 32'h0,   1, 1, 0, 32'h8,   0, 1)); // 4
    vecs.push_back(mk(0, 32'h8,   0, 0, 32'h0,   1, 1, 0, 32'hC,   0, 1)); // 5
    vecs.push_back(mk(0, 32'h10,  1, 0, 32'h0,   1, 1, 1, 32'h10,  0, 0)); // 6 hazard
    vecs.push_back(mk(0, 32'h10,  1, 0, 32'h0,   1, 1, 1, 32'h10,  0, 0)); // 7 hazard
    vecs.push_back(mk(0, 32'h10,  0, 0, 32'h0,   1, 1, 0, 32'h14,  0, 1)); // 8
    vecs.push_back(mk(0, 32'h20,  0, 1, 32'h103, 0, 1, 1, 32'h20,  1, 0)); // 9 -> DRAIN
    vecs.push_back(mk(0, 32'h20,  0, 0, 32'h0,   0, 1, 1, 32'h20,  0, 0)); // 10
    vecs.push_back(mk(0, 32'h20,  1, 0, 32'h0,   0, 1, 1, 32'h20,  0, 0)); // 11
    vecs.push_back(mk(0, 32'h20,  0, 0, 32'h0,   1, 1, 0, 32'h100, 0, 0)); // 12 drain done
    vecs.push_back(mk(0, 32'h100, 1, 1, 32'h40,  1, 1, 0, 32'h40,  1, 0)); // 13 redirect+ready+hazard
    vecs.push_back(mk(0, 32'h40,  0, 1, 32'h80,  0, 1, 1, 32'h40,  1, 0)); // 14 -> DRAIN
    vecs.push_back(mk(0, 32'h40,  0, 1, 32'hC0,  0, 1, 1, 32'h40,  1, 0)); // 15 overwrite
    vecs.push_back(mk(0, 32'h40,  0, 0, 32'h0,   1, 1, 0, 32'hC0,  0, 0)); // 16
    vecs.push_back(mk(0, 32'hC0,  0, 1, 32'h300, 0, 1, 1, 32'hC0,  1, 0)); // 17 -> DRAIN
    vecs.push_back(mk(0, 32'hC0,  0, 1, 32'h407, 1, 1, 0, 32'h404, 1, 0)); // 18 newest wins
    vecs.push_back(mk(0, 32'h404, 0, 0, 32'h0,   0, 1, 1, 32'h404, 0, 0)); // 19 mem wait
    vecs.push_back(mk(1, 32'h404, 0, 0, 32'h0,   0, 0, 1, 32'h0,   0, 0)); // 20 reset
    vecs.push_back(mk(0, 32'h404, 0, 1, 32'h600, 0, 0, 1, 32'h404, 1, 0)); // 21 BOOT redirect
    vecs.push_back(mk(0, 32'h404, 1, 0, 32'h0,   1, 1, 0, 32'h600, 0, 0)); // 22 hazard ignored
    vecs.push_back(mk(0, 32'hFFFFFFFC, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 1)); // 23 wrap
    vecs.push_back(mk(0, 32'h10,  0, 1, 32'h700, 0, 1, 1, 32'h10,  1, 0)); // 24 -> DRAIN
    vecs.push_back(mk(1, 32'h10,  0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 0)); // 25 reset mid-DRAIN
    vecs.push_back(mk(0, 32'h10,  0, 0, 32'h0,   1, 0, 1, 32'h10,  0, 0)); // 26 BOOT
    vecs.push_back(mk(0, 32'h10,  0, 0, 32'h0,   1, 1, 0, 32'h14,  0, 1)); // 27 no jump

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].hz, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d imem_addr", i),   imem_addr,            vecs[i].pc);
      chk($sformatf("v%0d stall_PC", i),    {31'b0, stall_PC},    {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d PC_in", i),       PC_in,                vecs[i].e_pcin);
      chk($sformatf("v%0d flush_IF_ID", i), {31'b0, flush_IF_ID}, {31'b0, vecs[i].e_flush});
      chk($sformatf("v%0d if_valid", i),    {31'b0, if_valid},    {31'b0, vecs[i].e_valid});
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    // Counter sequence: 5 fetches, 2 hazard stalls, 1 redirect with ready.
    drive(1, 0, 0, 0, 0, 1); @(negedge clk);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);          // BOOT
    for (int k = 0; k < 5; k++) begin
      drive(0, 32'(k * 4), 0, 0, 0, 1); @(negedge clk);
    end
    drive(0, 32'h14, 1, 0, 0, 1); @(negedge clk);
    drive(0, 32'h14, 1, 0, 0, 1); @(negedge clk);
    drive(0, 32'h14, 0, 1, 32'h200, 1); @(negedge clk);
    drive(0, 32'h200, 0, 0, 0, 0);
    #1;
    chk("perf_fetch_cnt",    perf_fetch_cnt,    32'd5);
    chk("perf_stall_cnt",    perf_stall_cnt,    32'd2);
    chk("perf_redirect_cnt", perf_redirect_cnt, 32'd1);
    @(negedge clk);                                    // wait cycle: stall 3
    drive(0, 32'h200, 0, 1, 32'h300, 0); @(negedge clk); // -> DRAIN: stall 4, redir 2
    drive(0, 32'h200, 0, 0, 0, 0); #1;
    chk("perf_stall_cnt drain",    perf_stall_cnt,    32'd4);
    chk("perf_redirect_cnt drain", perf_redirect_cnt, 32'd2);
    @(negedge clk);
    drive(1, 32'h200, 0, 0, 0, 1); @(negedge clk);     // reset mid-DRAIN
    drive(0, 32'h50, 0, 0, 0, 1); #1;
    chk("perf_fetch_cnt rst",    perf_fetch_cnt,    32'd0);
    chk("perf_stall_cnt rst",    perf_stall_cnt,    32'd0);
    chk("perf_redirect_cnt rst", perf_redirect_cnt, 32'd0);
    chk("post-rst BOOT stall",   {31'b0, stall_PC}, 32'd1);
    @(negedge clk);
    drive(0, 32'h50, 0, 0, 0, 1); #1;
    chk("post-rst PC_in", PC_in, 32'h54);
    chk("post-rst perf_stall_cnt BOOT excluded", perf_stall_cnt, 32'd0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage sequencer that drives the PC register's `PC_in` and `stall_PC` inputs. It handles the instruction-memory request/ready handshake, load-use stalls and EX-stage branch/jump redirects. It sits between the PC register, the instruction memory and the IF/ID pipeline register. It decides every cycle whether the PC advances, holds, or jumps, and whether the fetched word is valid.

## Interface
- `PC_INC`, default 4: sequential PC increment in bytes.
- `CNT_W`, default 32: width of the performance counters; only used under `FETCH_PERF_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_cur`  in  32  current PC, i.e. the PC register's `PC_out`.
- `hazard_stall`  in  1  load-use stall request from the ID-stage hazard unit.
- `redirect_valid`  in  1  EX-stage taken branch or jump, one-cycle pulse.
- `redirect_target`  in  32  redirect destination.
- `imem_ready`  in  1  instruction memory returns data for the current request this cycle.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address.
- `PC_in`  out  32  next PC to the PC register.
- `stall_PC`  out  1  PC register hold.
- `flush_IF_ID`  out  1  invalidate the IF/ID register.
- `if_valid`  out  1  fetched word is to be captured into IF/ID this cycle.
- `perf_fetch_cnt`, `perf_stall_cnt`, `perf_redirect_cnt`  out  `CNT_W` each. These ports exist only under `FETCH_PERF_EN`.

## Operation
- Registered state: `state` ∈ {BOOT, FETCH, DRAIN}, `pend_target[31:0]`, and the counters when enabled.
- Outputs are combinational from the registered state and the current inputs.
- `imem_addr` = `pc_cur` always.
- `redirect_target[1:0]` is forced to 0 wherever the target is used.
- BOOT:
  - Entered on reset.
  - Drives `imem_req`=0, `stall_PC`=1, `if_valid`=0.
  - Moves to FETCH after one cycle.
  - A `redirect_valid` seen in BOOT is latched into `pend_target`, `flush_IF_ID`=1, and the state moves to DRAIN.
- FETCH, `imem_req`=1. Cases in priority order:
  - `redirect_valid` && `imem_ready`: `PC_in`=target, `stall_PC`=0, `flush_IF_ID`=1, `if_valid`=0. Stay in FETCH.
  - `redirect_valid` && !`imem_ready`: latch target into `pend_target`, `flush_IF_ID`=1, `stall_PC`=1, `if_valid`=0. Go to DRAIN.
  - `imem_ready` && `hazard_stall`: `stall_PC`=1, `if_valid`=0. The same PC is re-fetched next cycle.
  - `imem_ready`: `PC_in`=`pc_cur`+`PC_INC` (mod 2^32), `stall_PC`=0, `if_valid`=1.
  - Otherwise (memory waiting): `stall_PC`=1, `if_valid`=0.
- DRAIN:
  - `imem_req` stays 1 at the same address until `imem_ready`. An issued request is never abandoned.
  - A further `redirect_valid` in DRAIN overwrites `pend_target` and asserts `flush_IF_ID`=1.
  - On `imem_ready`: the returned word is discarded (`if_valid`=0), `PC_in` = the newest target (the input if `redirect_valid` is high this cycle, else `pend_target`), `stall_PC`=0. Go to FETCH.
- When `stall_PC`=0 is not specified above, `PC_in` = `pc_cur`. When `stall_PC`=1, `PC_in` = `pc_cur`.
- `hazard_stall` is ignored in BOOT and DRAIN.

## Timing
- Reset: the state goes to BOOT and `pend_target`=0, counters=0.
- Outputs while `reset` is high: `imem_req`=0, `stall_PC`=1, `PC_in`=0, `flush_IF_ID`=0, `if_valid`=0.
- Reset asserted mid-DRAIN discards the pending redirect.
- First fetch request occurs in the second cycle after `reset` deasserts.
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle. The PC register shows `pc_cur`+4 on the edge after the fetch cycle.
- Redirect latency: the PC register holds the target at the first edge where `imem_ready`=1, at or after the `redirect_valid` cycle.
- `flush_IF_ID` is high exactly in cycles where `redirect_valid`=1. It is never asserted in the same cycle as `if_valid`.

## Configuration
- `FETCH_PERF_EN` defined: the three counters exist, are saturating, and are cleared by reset.
  - `perf_fetch_cnt` +1 per `if_valid` cycle.
  - `perf_stall_cnt` +1 per `stall_PC` cycle outside BOOT.
  - `perf_redirect_cnt` +1 per `redirect_valid` cycle.
- `FETCH_PERF_EN` undefined: the counters, their ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `imem_ready`=1, `pc_cur` tracking `PC_in` → BOOT for 1 cycle, then `PC_in`=0x4, 0x8, 0xC on consecutive cycles with `if_valid`=1.
- `pc_cur`=0x10, `hazard_stall`=1 for 2 cycles → `stall_PC`=1, `if_valid`=0 for 2 cycles; then `PC_in`=0x14.
- `imem_ready`=0 for 3 cycles at `pc_cur`=0x20, `redirect_valid` with target 0x103 in cycle 1 → `flush_IF_ID`=1 in cycle 1, `imem_req`/`imem_addr`=0x20 held; when ready, `PC_in`=0x100, `if_valid`=0.
- `redirect_valid`=1 (target 0x40), `imem_ready`=1 and `hazard_stall`=1 in the same cycle → `PC_in`=0x40, `stall_PC`=0, `flush_IF_ID`=1.
- In DRAIN with target 0x80 pending, a second redirect to 0xC0, then ready → `PC_in`=0xC0.
- With `FETCH_PERF_EN`: 5 fetches, 2 stalls, 1 redirect → counters read 5/2/1. Reset asserted mid-DRAIN → BOOT, counters 0, no jump applied.
